clk_divider_param: RTL and testbench
====================================

Name: clk_divider_param

Overview:
Parametrised, runtime-programmable clock-enable generator. It replaces fixed chained dividers such as 100 MHz to 1 kHz to 1 Hz. A primary counter divides clk by a loadable divisor and emits a one-cycle tick plus a 50%-duty toggled output. A cascaded secondary stage divides the primary tick by a fixed factor. All outputs are synchronous to clk; nothing downstream is clocked by a divided signal.

Parameters:
CNT_W, 27, width of primary counter and divisor.
DEFAULT_DIV, 50000, primary divisor after reset (100 MHz gives a 2 kHz tick and a 1 kHz div_signal).
SLOW_DIV, 1000, number of primary ticks per secondary tick (SLOW_DIV must be at least 1).
SLOW_W, 10, width of secondary counter (must hold SLOW_DIV-1).

Ports:
clk  in  1  system clock; one clock domain.
rst_n  in  1  reset, asynchronous, active-low.
en  in  1  count enable; low pauses both stages.
clr  in  1  synchronous clear of counters and outputs.
div_load  in  1  one-cycle strobe; captures div_value.
div_value  in  CNT_W  requested primary divisor N.
tick  out  1  one-cycle primary enable strobe.
div_signal  out  1  toggles on every tick (period 2N cycles).
tick_slow  out  1  one-cycle secondary strobe.
slow_signal  out  1  toggles on every tick_slow.
active_div  out  CNT_W  divisor currently in force.
load_pending  out  1  a captured divisor is waiting for a wrap.

Behaviour:
- Reset (rst_n low, asynchronous): cnt=0, slow_cnt=0, tick=0, div_signal=0, tick_slow=0, slow_signal=0, active_div=DEFAULT_DIV, pending=0, load_pending=0.
- Primary stage, en=1, active_div=N with N≥1: cnt increments each cycle. When cnt==N-1, cnt wraps to 0. tick is registered: it is high for exactly the one cycle following the cycle in which cnt==N-1. div_signal toggles in that same cycle. One tick every N cycles.
- N=1: tick is held high continuously and div_signal toggles every cycle (clk/2).
- N=0: primary stage is disabled. cnt holds at 0, no ticks are generated, div_signal holds its value. A pending load applies on the next cycle.
- en=0: cnt and slow_cnt hold, tick=0, tick_slow=0, toggled outputs hold. Resuming continues from the held count with no extra or lost tick.
- Divisor load: div_load=1 captures div_value into pending and sets load_pending.
  - Pending is applied to active_div at the next wrap, meaning the cycle where cnt==N-1 with en=1. load_pending clears in that cycle.
  - If div_load coincides with that wrap cycle, the new value applies at that same wrap.
  - If the current active_div is 0, the load applies on the next cycle.
  - A second div_load before application overwrites pending (last write wins).
  - The in-progress period always completes at the old N, so no glitch or short period occurs.
- Secondary stage: updates only on cycles where the registered primary enable fires. slow_cnt increments; at SLOW_DIV-1 it wraps to 0. tick_slow is high for the cycle after the wrap and slow_signal toggles in that cycle. Latency from the corresponding tick to tick_slow is 1 cycle.
- clr=1 (synchronous, priority over en and counting):
  - cnt=0, slow_cnt=0, tick=0, tick_slow=0, div_signal=0, slow_signal=0.
  - If pending is valid, or div_load is high in the same cycle, the new divisor is applied immediately and load_pending clears.
- Asynchronous reset asserted mid-count returns all state to reset values immediately, with no clock edge required. On release, counting restarts from 0 at DEFAULT_DIV.
- Arithmetic: unsigned. Compare against active_div-1 computed in CNT_W bits, with the N=0 and N=1 cases handled explicitly. No overflow is possible because cnt never exceeds N-1.

Test Plan:
- Reset release with DEFAULT_DIV=4, SLOW_DIV=3, en=1 -> tick pulses every 4 cycles, first 4 cycles after release; div_signal period 8, 50% duty; tick_slow on every 3rd tick; slow_signal period 24 cycles.
- Load div_value=6 at cnt=1 while N=4 -> load_pending=1; current period completes after 4 cycles; then ticks every 6 cycles; active_div reads 6 from the wrap; load_pending=0.
- Load 0, then later load 3 -> ticks stop after the current period and div_signal is frozen; after loading 3, ticks resume every 3 cycles starting from cnt=0.
- en deasserted at cnt=2 for 10 cycles with N=4 -> no ticks while paused; the first tick comes 2 cycles after re-enable; tick-to-tick interval, counted in enabled cycles only, is exactly 4.
- clr asserted together with div_load (value 5) at cnt=3 -> next cycle all outputs 0, active_div=5, load_pending=0; next tick 5 cycles later.
- rst_n pulsed low between clock edges mid-period -> outputs go to reset values without a clock edge; after release, ticks resume at DEFAULT_DIV and slow_cnt restarts at 0.

Source files
------------

// File: rtl/clk_divider_param.sv
// Runtime-programmable clock-enable generator: a loadable primary divider followed
// by a fixed secondary divider, all outputs synchronous to clk.
module clk_divider_param #(
  parameter int CNT_W       = 27,
  parameter int DEFAULT_DIV = 50000,
  parameter int SLOW_DIV    = 1000,
  parameter int SLOW_W      = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_value,
  output logic             tick,
  output logic             div_signal,
  output logic             tick_slow,
  output logic             slow_signal,
  output logic [CNT_W-1:0] active_div,
  output logic             load_pending
);

  localparam logic [CNT_W-1:0]  DEF_DIV   = CNT_W'(DEFAULT_DIV);
  localparam logic [SLOW_W-1:0] SLOW_LAST = SLOW_W'(SLOW_DIV - 1);

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  pending;
  logic [SLOW_W-1:0] slow_cnt;

  logic div_zero;
  logic div_one;
  logic cnt_last;
  logic wrap;
  logic apply_div;
  logic slow_last;

  // N=1 wraps every cycle; N=0 never wraps, so a waiting divisor is taken at once
  assign div_zero  = (active_div == '0);
  assign div_one   = (active_div == CNT_W'(1));
  assign cnt_last  = div_one || (cnt == active_div - CNT_W'(1));
  assign wrap      = en && !div_zero && cnt_last;
  assign apply_div = wrap || div_zero;
  assign slow_last = (slow_cnt == SLOW_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_div   <= DEF_DIV;
      pending      <= '0;
      load_pending <= 1'b0;
    end else if (clr || apply_div) begin
      if (div_load) begin
        active_div   <= div_value;
        load_pending <= 1'b0;
      end else if (load_pending) begin
        active_div   <= pending;
        load_pending <= 1'b0;
      end
    end else if (div_load) begin
      pending      <= div_value;
      load_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      tick       <= 1'b0;
      div_signal <= 1'b0;
    end else if (clr) begin
      cnt        <= '0;
      tick       <= 1'b0;
      div_signal <= 1'b0;
    end else if (!en) begin
      tick <= 1'b0;
    end else if (div_zero) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick       <= cnt_last;
      div_signal <= div_signal ^ cnt_last;
      cnt        <= cnt_last ? '0 : cnt + CNT_W'(1);
    end
  end

  // Secondary stage advances on the registered primary tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slow_cnt    <= '0;
      tick_slow   <= 1'b0;
      slow_signal <= 1'b0;
    end else if (clr) begin
      slow_cnt    <= '0;
      tick_slow   <= 1'b0;
      slow_signal <= 1'b0;
    end else if (!en) begin
      tick_slow <= 1'b0;
    end else begin
      tick_slow   <= tick && slow_last;
      slow_signal <= slow_signal ^ (tick && slow_last);
      if (tick)
        slow_cnt <= slow_last ? '0 : slow_cnt + SLOW_W'(1);
    end
  end

endmodule

// File: tb/tb_clk_divider_param.sv
// Directed bench for clk_divider_param with DEFAULT_DIV=4 and SLOW_DIV=3.
module tb_clk_divider_param;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             clr;
  logic             div_load;
  logic [CNT_W-1:0] div_value;
  logic             tick;
  logic             div_signal;
  logic             tick_slow;
  logic             slow_signal;
  logic [CNT_W-1:0] active_div;
  logic             load_pending;

  int checks   = 0;
  int failures = 0;

  clk_divider_param #(
    .CNT_W      (CNT_W),
    .DEFAULT_DIV(4),
    .SLOW_DIV   (3),
    .SLOW_W     (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .clr         (clr),
    .div_load    (div_load),
    .div_value   (div_value),
    .tick        (tick),
    .div_signal  (div_signal),
    .tick_slow   (tick_slow),
    .slow_signal (slow_signal),
    .active_div  (active_div),
    .load_pending(load_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // {tick, div_signal, tick_slow, slow_signal} i cycles after reset release at N=4
  function automatic logic [3:0] exp_default(int i);
    return {(i % 4 == 0), ((i / 4) % 2 == 1), (i >= 13 && i % 12 == 1), (((i - 1) / 12) % 2 == 1)};
  endfunction

  task automatic restart();
    en = 1'b0; clr = 1'b0; div_load = 1'b0; div_value = '0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    en = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) cyc();
    checks++;
    if ({tick, div_signal, tick_slow, slow_signal} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0000", {tick, div_signal, tick_slow, slow_signal});
    end
    checks++;
    if (active_div !== 8'd4 || load_pending !== 1'b0) begin
      failures++;
      $display("FAIL reset_div got=%0d/%b exp=4/0", active_div, load_pending);
    end
  endtask

  task automatic test_default();
    restart();
    for (int i = 1; i <= 36; i++) begin
      cyc();
      checks++;
      if ({tick, div_signal, tick_slow, slow_signal} !== exp_default(i)) begin
        failures++;
        $display("FAIL default_c%0d got=%b exp=%b", i, {tick, div_signal, tick_slow, slow_signal}, exp_default(i));
      end
    end
  endtask

  task automatic test_load();
    restart();
    div_load = 1'b1; div_value = 8'd9;
    cyc();
    div_value = 8'd6;
    cyc();
    div_load = 1'b0;
    checks++;
    if (load_pending !== 1'b1 || active_div !== 8'd4) begin
      failures++;
      $display("FAIL load_pending got=%b/%0d exp=1/4", load_pending, active_div);
    end
    cyc();
    checks++;
    if (tick !== 1'b0 || active_div !== 8'd4) begin
      failures++;
      $display("FAIL load_old_period got=%b/%0d exp=0/4", tick, active_div);
    end
    cyc();
    checks++;
    if (tick !== 1'b1 || active_div !== 8'd6 || load_pending !== 1'b0) begin
      failures++;
      $display("FAIL load_apply got=%b/%0d/%b exp=1/6/0", tick, active_div, load_pending);
    end
    for (int j = 1; j <= 12; j++) begin
      cyc();
      checks++;
      if ({tick, div_signal} !== {(j % 6 == 0), ((j / 6) % 2 == 0)}) begin
        failures++;
        $display("FAIL load_n6_c%0d got=%b exp=%b", j, {tick, div_signal}, {(j % 6 == 0), ((j / 6) % 2 == 0)});
      end
    end
  endtask

  task automatic test_zero();
    restart();
    cyc();
    div_load = 1'b1; div_value = 8'd0;
    cyc();
    div_load = 1'b0;
    repeat (2) cyc();
    checks++;
    if (tick !== 1'b1 || div_signal !== 1'b1 || active_div !== 8'd0) begin
      failures++;
      $display("FAIL zero_apply got=%b/%b/%0d exp=1/1/0", tick, div_signal, active_div);
    end
    for (int j = 1; j <= 8; j++) begin
      cyc();
      checks++;
      if ({tick, div_signal} !== 2'b01) begin
        failures++;
        $display("FAIL zero_frozen_c%0d got=%b exp=01", j, {tick, div_signal});
      end
    end
    div_load = 1'b1; div_value = 8'd3;
    cyc();
    div_load = 1'b0;
    checks++;
    if (active_div !== 8'd3 || load_pending !== 1'b0 || tick !== 1'b0) begin
      failures++;
      $display("FAIL zero_reload got=%0d/%b/%b exp=3/0/0", active_div, load_pending, tick);
    end
    for (int j = 1; j <= 9; j++) begin
      cyc();
      checks++;
      if ({tick, div_signal} !== {(j % 3 == 0), ((j / 3) % 2 == 0)}) begin
        failures++;
        $display("FAIL zero_n3_c%0d got=%b exp=%b", j, {tick, div_signal}, {(j % 3 == 0), ((j / 3) % 2 == 0)});
      end
    end
  endtask

  task automatic test_pause();
    restart();
    repeat (2) cyc();
    en = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      cyc();
      checks++;
      if ({tick, div_signal} !== 2'b00) begin
        failures++;
        $display("FAIL pause_c%0d got=%b exp=00", j, {tick, div_signal});
      end
    end
    en = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      cyc();
      checks++;
      if ({tick, div_signal} !== {(j % 4 == 2), (j >= 2 && ((j - 2) / 4) % 2 == 0)}) begin
        failures++;
        $display("FAIL resume_c%0d got=%b exp=%b", j, {tick, div_signal}, {(j % 4 == 2), (j >= 2 && ((j - 2) / 4) % 2 == 0)});
      end
    end
  endtask

  task automatic test_clr();
    restart();
    repeat (13) cyc();
    checks++;
    if ({div_signal, tick_slow, slow_signal} !== 3'b111) begin
      failures++;
      $display("FAIL clr_precond got=%b exp=111", {div_signal, tick_slow, slow_signal});
    end
    repeat (2) cyc();
    clr = 1'b1; div_load = 1'b1; div_value = 8'd5;
    cyc();
    clr = 1'b0; div_load = 1'b0;
    checks++;
    if ({tick, div_signal, tick_slow, slow_signal} !== 4'b0000 || active_div !== 8'd5 || load_pending !== 1'b0) begin
      failures++;
      $display("FAIL clr_apply got=%b/%0d/%b exp=0000/5/0", {tick, div_signal, tick_slow, slow_signal}, active_div, load_pending);
    end
    for (int j = 1; j <= 10; j++) begin
      cyc();
      checks++;
      if ({tick, div_signal, tick_slow, slow_signal} !== {(j % 5 == 0), ((j / 5) % 2 == 1), 2'b00}) begin
        failures++;
        $display("FAIL clr_n5_c%0d got=%b exp=%b", j, {tick, div_signal, tick_slow, slow_signal}, {(j % 5 == 0), ((j / 5) % 2 == 1), 2'b00});
      end
    end
  endtask

  task automatic test_div_one();
    restart();
    clr = 1'b1; div_load = 1'b1; div_value = 8'd1;
    cyc();
    clr = 1'b0; div_load = 1'b0;
    checks++;
    if ({tick, div_signal} !== 2'b00 || active_div !== 8'd1) begin
      failures++;
      $display("FAIL one_apply got=%b/%0d exp=00/1", {tick, div_signal}, active_div);
    end
    for (int j = 1; j <= 6; j++) begin
      cyc();
      checks++;
      if ({tick, div_signal} !== {1'b1, (j % 2 == 1)}) begin
        failures++;
        $display("FAIL one_c%0d got=%b exp=%b", j, {tick, div_signal}, {1'b1, (j % 2 == 1)});
      end
    end
    div_load = 1'b1; div_value = 8'd3;
    cyc();
    div_load = 1'b0;
    checks++;
    if ({tick, div_signal} !== 2'b11 || active_div !== 8'd3 || load_pending !== 1'b0) begin
      failures++;
      $display("FAIL wrap_load got=%b/%0d/%b exp=11/3/0", {tick, div_signal}, active_div, load_pending);
    end
    for (int k = 1; k <= 6; k++) begin
      cyc();
      checks++;
      if ({tick, div_signal} !== {(k % 3 == 0), ((k / 3) % 2 == 0)}) begin
        failures++;
        $display("FAIL wrap_n3_c%0d got=%b exp=%b", k, {tick, div_signal}, {(k % 3 == 0), ((k / 3) % 2 == 0)});
      end
    end
  endtask

  task automatic test_async_reset();
    restart();
    repeat (13) cyc();
    div_load = 1'b1; div_value = 8'd7;
    cyc();
    div_load = 1'b0;
    checks++;
    if ({div_signal, slow_signal, load_pending} !== 3'b111) begin
      failures++;
      $display("FAIL areset_precond got=%b exp=111", {div_signal, slow_signal, load_pending});
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tick, div_signal, tick_slow, slow_signal} !== 4'b0000 || active_div !== 8'd4 || load_pending !== 1'b0) begin
      failures++;
      $display("FAIL areset_immediate got=%b/%0d/%b exp=0000/4/0", {tick, div_signal, tick_slow, slow_signal}, active_div, load_pending);
    end
    cyc();
    rst_n = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      cyc();
      checks++;
      if ({tick, div_signal, tick_slow, slow_signal} !== exp_default(i)) begin
        failures++;
        $display("FAIL areset_resume_c%0d got=%b exp=%b", i, {tick, div_signal, tick_slow, slow_signal}, exp_default(i));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; div_load = 1'b0; div_value = '0;
    test_reset();
    test_default();
    test_load();
    test_zero();
    test_pause();
    test_clr();
    test_div_one();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
